// File: rtl/firstband_pkg.sv
// Shared definitions for the first-band predictor (encoder) and reconstructor (decoder).
// Both sides import this package so they form bit-identical predictions.
package firstband_pkg;

   localparam int DATA_WIDTH          = 16;
   localparam int BLOCK_WIDTH_LOG_MAX = 4;
   localparam int RES_WIDTH           = DATA_WIDTH + 1;

   typedef enum logic [1:0] {
      PRED_NONE,
      PRED_LEFT,
      PRED_UP,
      PRED_AVG
   } pred_mode_t;

   // Saturate a signed value into the unsigned range [0, 2^w - 1].
   // Kept width-generic so either side can use it with its own DATA_WIDTH.
   function automatic logic [31:0] clamp_sample(input logic signed [31:0] v,
                                                input int unsigned w);
      logic signed [31:0] max_v;
      max_v = (32'sd1 <<< w) - 32'sd1;
      if (v < 0)
         return '0;
      else if (v > max_v)
         return max_v;
      else
         return v;
   endfunction

endpackage

// File: rtl/firstband_row_buffer.sv
// One block row of previously decoded samples. Read is asynchronous at addr,
// write is synchronous at the same addr, so a same-cycle read returns the
// previous row's value. Contents are intentionally not reset.
module firstband_row_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   assign rdata = mem_q[addr];

   // Store the reconstructed sample for use as "up" on the next row
   always_ff @(posedge clk) begin
      if (we)
         mem_q[addr] <= wdata;
   end

endmodule

// File: rtl/firstband_reconstructor.sv
// Decoder-side first-band reconstructor: rebuilds the encoder's prediction
// from already decoded neighbours and adds the residual. Single output
// register, one sample per cycle, latency 1.
module firstband_reconstructor #(
   parameter int DATA_WIDTH          = 16,
   parameter int BLOCK_WIDTH_LOG_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  e_valid,
   output logic                  e_ready,
   input  logic [DATA_WIDTH:0]   e_data,
   input  logic                  e_last_row,
   input  logic                  e_last_slice,
   output logic                  x_valid,
   input  logic                  x_ready,
   output logic [DATA_WIDTH-1:0] x_data,
   output logic                  x_last_row,
   output logic                  x_last_slice
);

   import firstband_pkg::*;

   logic [BLOCK_WIDTH_LOG_MAX-1:0] col_q, col_d;
   logic                           first_row_q, first_row_d;
   logic [DATA_WIDTH-1:0]          left_q, left_d;
   logic                           x_valid_q, x_valid_d;
   logic [DATA_WIDTH-1:0]          x_data_q, x_data_d;
   logic                           x_last_row_q, x_last_row_d;
   logic                           x_last_slice_q, x_last_slice_d;

   logic                           accept;
   logic [DATA_WIDTH-1:0]          up;
   logic [DATA_WIDTH-1:0]          xtilde;
   logic [DATA_WIDTH:0]            pair_sum;
   logic signed [DATA_WIDTH+1:0]   recon;
   logic [DATA_WIDTH-1:0]          x_new;
   pred_mode_t                     pred_mode;

   // A new residual may enter whenever the output register is empty or draining
   assign e_ready = !x_valid_q || x_ready;
   assign accept  = e_valid && e_ready;

   assign x_valid      = x_valid_q;
   assign x_data       = x_data_q;
   assign x_last_row   = x_last_row_q;
   assign x_last_slice = x_last_slice_q;

   firstband_row_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (BLOCK_WIDTH_LOG_MAX)
   ) u_row_buffer (
      .clk   (clk),
      .addr  (col_q),
      .we    (accept),
      .wdata (x_new),
      .rdata (up)
   );

   // Pick the predictor from position within the block
   always_comb begin
      pred_mode = PRED_AVG;
      if (first_row_q && (col_q == '0))
         pred_mode = PRED_NONE;
      else if (first_row_q)
         pred_mode = PRED_LEFT;
      else if (col_q == '0)
         pred_mode = PRED_UP;
   end

   // Form the prediction, add the residual and saturate to the sample range
   always_comb begin
      pair_sum = {1'b0, left_q} + {1'b0, up};
      case (pred_mode)
         PRED_NONE: xtilde = '0;
         PRED_LEFT: xtilde = left_q;
         PRED_UP:   xtilde = up;
         PRED_AVG:  xtilde = DATA_WIDTH'(pair_sum >> 1);
         default:   xtilde = '0;
      endcase
      recon = $signed({2'b00, xtilde}) + $signed({e_data[DATA_WIDTH], e_data});
      x_new = DATA_WIDTH'(clamp_sample(32'(recon), DATA_WIDTH));
   end

   // Next-state: output register handshake plus block position tracking
   always_comb begin
      col_d          = col_q;
      first_row_d    = first_row_q;
      left_d         = left_q;
      x_valid_d      = x_valid_q;
      x_data_d       = x_data_q;
      x_last_row_d   = x_last_row_q;
      x_last_slice_d = x_last_slice_q;

      if (accept) begin
         x_valid_d      = 1'b1;
         x_data_d       = x_new;
         x_last_row_d   = e_last_row;
         x_last_slice_d = e_last_slice;
         left_d         = x_new;
         // end of block wins over end of row: the next sample starts a fresh block
         if (e_last_slice) begin
            col_d       = '0;
            first_row_d = 1'b1;
         end else if (e_last_row) begin
            col_d       = '0;
            first_row_d = 1'b0;
         end else begin
            col_d = col_q + 1'b1;
         end
      end else if (x_ready) begin
         x_valid_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q          <= '0;
         first_row_q    <= 1'b1;
         left_q         <= '0;
         x_valid_q      <= 1'b0;
         x_data_q       <= '0;
         x_last_row_q   <= 1'b0;
         x_last_slice_q <= 1'b0;
      end else begin
         col_q          <= col_d;
         first_row_q    <= first_row_d;
         left_q         <= left_d;
         x_valid_q      <= x_valid_d;
         x_data_q       <= x_data_d;
         x_last_row_q   <= x_last_row_d;
         x_last_slice_q <= x_last_slice_d;
      end
   end

endmodule

// File: tb/tb_firstband_reconstructor.sv
// Scoreboard bench for firstband_reconstructor: the driver pushes the model's
// expected sample on every accepted residual, the monitor pops on every
// output transfer.
module tb_firstband_reconstructor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        e_valid = 1'b0;
   logic        e_ready;
   logic [16:0] e_data = '0;
   logic        e_last_row = 1'b0;
   logic        e_last_slice = 1'b0;
   logic        x_valid;
   logic        x_ready = 1'b1;
   logic [15:0] x_data;
   logic        x_last_row;
   logic        x_last_slice;

   firstband_reconstructor #(
      .DATA_WIDTH          (16),
      .BLOCK_WIDTH_LOG_MAX (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .e_valid      (e_valid),
      .e_ready      (e_ready),
      .e_data       (e_data),
      .e_last_row   (e_last_row),
      .e_last_slice (e_last_slice),
      .x_valid      (x_valid),
      .x_ready      (x_ready),
      .x_data       (x_data),
      .x_last_row   (x_last_row),
      .x_last_slice (x_last_slice)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      bit lr;
      bit ls;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // reference model state: a row of decoded samples and the block position
   int m_buf[16];
   int m_left;
   int m_col;
   bit m_first;

   int hold_zero = 0;
   bit rand_ready = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_col   = 0;
      m_first = 1;
      m_left  = 0;
      foreach (m_buf[i]) m_buf[i] = 0;
   endfunction

   function automatic int model_step(int e, bit lr, bit ls);
      int up;
      int pred;
      int x;
      up = m_buf[m_col];
      if (m_first)
         pred = (m_col == 0) ? 0 : m_left;
      else
         pred = (m_col == 0) ? up : (m_left + up) / 2;
      x = pred + e;
      if (x < 0) x = 0;
      if (x > 65535) x = 65535;
      m_buf[m_col] = x;
      m_left = x;
      if (ls) begin
         m_col = 0;
         m_first = 1;
      end else if (lr) begin
         m_col = 0;
         m_first = 0;
      end else begin
         m_col = (m_col + 1) % 16;
      end
      return x;
   endfunction

   function automatic bit pick_ready();
      if (hold_zero > 0) begin
         hold_zero--;
         return 1'b0;
      end
      if (rand_ready)
         return ($urandom_range(0, 3) != 0);
      return 1'b1;
   endfunction

   task automatic send(input int e, input bit lr, input bit ls);
      bit done = 0;
      exp_t it;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         x_ready      = pick_ready();
         e_valid      = 1'b1;
         e_data       = 17'(e);
         e_last_row   = lr;
         e_last_slice = ls;
         #1;
         check("e_ready", int'(e_ready), int'(sb.size() == 0 || x_ready));
         if (e_ready) begin
            it.x  = model_step(e, lr, ls);
            it.lr = lr;
            it.ls = ls;
            sb.push_back(it);
            done = 1;
            @(posedge clk);
         end
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: residual %0d not accepted, expected accept within 200 cycles", e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         x_ready = pick_ready();
         e_valid = 1'b0;
      end
   endtask

   task automatic drain();
      rand_ready = 0;
      hold_zero  = 0;
      for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
      idle(1);
      check("drain_empty", sb.size(), 0);
   endtask

   function automatic int rand_e();
      if ($urandom_range(0, 7) == 0)
         return int'($urandom_range(0, 131071)) - 65536;
      return int'($urandom_range(0, 400)) - 200;
   endfunction

   task automatic rand_block(input int w, input int h);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            send(rand_e(), (c == w - 1), (c == w - 1) && (r == h - 1));
   endtask

   // Monitor: compare every output transfer against the scoreboard head,
   // and check a stalled output still shows the expected sample
   initial begin
      exp_t mit;
      forever begin
         @(negedge clk);
         #3;
         if (rst && x_valid) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_output: x_data=%0d, expected no output", x_data);
            end else if (x_ready) begin
               mit = sb.pop_front();
               check("x_data", int'(x_data), mit.x);
               check("x_last_row", int'(x_last_row), int'(mit.lr));
               check("x_last_slice", int'(x_last_slice), int'(mit.ls));
            end else begin
               check("x_hold", int'(x_data), sb[0].x);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_x_valid", int'(x_valid), 0);
      check("rst_x_data", int'(x_data), 0);
      check("rst_x_last_row", int'(x_last_row), 0);
      check("rst_x_last_slice", int'(x_last_slice), 0);
      check("rst_e_ready", int'(e_ready), 1);
      @(negedge clk);
      rst = 1'b1;

      // two 2x2 blocks: 5,8,7,8 then 4,4,4,4
      send(5, 0, 0); send(3, 1, 0); send(2, 0, 0); send(1, 1, 1);
      send(4, 0, 0); send(0, 1, 0); send(0, 0, 0); send(0, 1, 1);
      drain();

      // clamping: 1x1 block -> 0; 1x2 block -> 65535, 65535
      send(-3, 1, 1);
      send(65535, 0, 0); send(10, 1, 1);
      drain();

      // rows of length 1: 7, 8, 6
      send(7, 1, 0); send(1, 1, 0); send(-2, 1, 1);
      drain();

      // backpressure for 5 cycles mid-row
      send(10, 0, 0); send(20, 0, 0);
      hold_zero = 5;
      send(30, 0, 0); send(-5, 0, 0); send(100, 0, 0); send(7, 1, 0);
      send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 1);
      drain();

      // asynchronous reset with col=3
      send(1, 0, 0); send(2, 0, 0); send(3, 0, 0);
      #1;
      check("pre_rst_x_valid", int'(x_valid), 1);
      #1;
      rst = 1'b0;
      e_valid = 1'b0;
      #1;
      check("async_rst_x_valid", int'(x_valid), 0);
      check("async_rst_x_data", int'(x_data), 0);
      sb.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      send(9, 1, 1);
      drain();

      // 16x16 block with random downstream readiness
      rand_ready = 1;
      rand_block(16, 16);
      drain();

      // assorted random block shapes
      for (int b = 0; b < 6; b++) begin
         rand_ready = ($urandom_range(0, 1) == 1);
         rand_block(int'($urandom_range(1, 16)), int'($urandom_range(1, 4)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/firstband_reconstructor.md
Name: firstband_reconstructor

Overview:
- Decoder-side counterpart of the first-band predictor: accepts first-band prediction residuals and rebuilds the original samples.
- Rebuilds the same prediction the encoder formed from already-decoded neighbours, then adds the residual.
- Sits after the entropy decoder / residual unmapper; its output stream also feeds the later-band decoders.

Parameters:
DATA_WIDTH, 16, sample width (unsigned samples)
BLOCK_WIDTH_LOG_MAX, 4, log2 of the maximum block row length; row buffer depth = 2^BLOCK_WIDTH_LOG_MAX

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
e_valid  in  1  residual valid
e_ready  out  1  residual ready
e_data  in  DATA_WIDTH+1  signed residual e = x - xtilde
e_last_row  in  1  residual is the last of its block row
e_last_slice  in  1  residual is the last of the block
x_valid  out  1  reconstructed sample valid
x_ready  in  1  downstream ready
x_data  out  DATA_WIDTH  reconstructed sample
x_last_row  out  1  e_last_row forwarded
x_last_slice  out  1  e_last_slice forwarded

Behaviour:
- One clock, clk; rst asynchronous active-low. While rst=0: x_valid=0, x_data=0, x_last_row=0, x_last_slice=0, col=0, first_row=1, left=0; row buffer contents are don't-care.
- Handshake: e_ready = !x_valid || x_ready (single output register, no combinational path from e_valid to x_valid). A residual is accepted when e_valid && e_ready. The accepted sample appears on x_* on the next cycle, so latency is 1. Full throughput is 1 sample/cycle when x_ready=1.
- x_* stay stable while x_valid && !x_ready. x_valid clears after an output transfer unless a new residual is accepted in the same cycle; a simultaneous transfer and accept reloads x_* with the new sample.
- Prediction, selected from first_row and col==0:
  - PRED_NONE (first_row, col 0): xtilde = 0
  - PRED_LEFT (first_row, col>0): xtilde = left
  - PRED_UP (!first_row, col 0): xtilde = up = rowbuf[col]
  - PRED_AVG (otherwise): xtilde = (left + up) >> 1, with the sum computed in DATA_WIDTH+1 bits and floored
- Reconstruction: x = xtilde + e, computed in DATA_WIDTH+2 bits signed, then clamped to [0, 2^DATA_WIDTH-1].
- On accept:
  - rowbuf[col] <= x
  - left <= x
  - if e_last_slice: col <= 0, first_row <= 1 (e_last_slice takes priority over e_last_row)
  - else if e_last_row: col <= 0, first_row <= 0
  - else col <= col+1
- Row buffer: read is combinational at col. The read and the write of the same address happen in the same cycle; the read returns the old (previous-row) value.
- col is BLOCK_WIDTH_LOG_MAX bits and wraps modulo 2^BLOCK_WIDTH_LOG_MAX if a row exceeds the maximum length. This is a protocol violation and is not flagged. Rows of length 1 are legal; in that case every sample uses PRED_NONE or PRED_UP.
- Reset mid-block discards all state. The first residual after reset is treated as the first sample of a new block.

Decomposition:
- Package firstband_pkg holds:
  - enum pred_mode_t {PRED_NONE, PRED_LEFT, PRED_UP, PRED_AVG}
  - function clamp_sample
  - localparam RES_WIDTH = DATA_WIDTH+1
  - the package is shared with the encoder-side predictor so both compute identical predictions
- Sub-module firstband_row_buffer: 2^BLOCK_WIDTH_LOG_MAX x DATA_WIDTH storage with asynchronous read and synchronous write, using the same address port for both.

Test Plan:
- 2x2 block, e = 5, 3, 2, 1 with last_row on samples 2 and 4 and last_slice on sample 4, x_ready=1 -> x = 5, 8, 7, 8. x_last_row and x_last_slice align with the inputs; one output per cycle after 1-cycle latency.
- Two consecutive 2x2 blocks, the second with e = 4, 0, 0, 0 -> second block x = 4, 4, 4, 4. This proves first_row is restored by last_slice and the buffer is not reused.
- Clamping: first sample e = -3 -> x = 0. In a 1x2 block, e = 65535 then e = 10 -> x = 65535, 65535.
- Backpressure: hold x_ready=0 for 5 cycles mid-row -> e_ready=0, x_data stable, no sample lost or duplicated. Random x_ready toggling over a golden-file 16x16 block -> output matches the golden sample file exactly.
- Reset asserted asynchronously mid-row (col=3) -> x_valid drops immediately. Next residual e = 9 -> x = 9 (PRED_NONE).
- Row of length 1 over 3 rows, e = 7, 1, -2 -> x = 7, 8, 6.
